axilite_reg_slave: RTL



---
 rtl/axilite_pkg.sv | 35 +++
 rtl/axilite_reg_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/axilite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axilite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Byte-lane merge: lane i takes new_word when strb[i] is set, else keeps old_word.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axilite_reg_slave.sv
// AXI4-Lite slave: NUM_REGS/2 RW control words followed by NUM_REGS/2 live RO status words.
// Define AXILITE_REG_SLAVE_SLVERR_EN to answer RO writes and out-of-range accesses with SLVERR.
module axilite_reg_slave
    import axilite_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 8,
    parameter int unsigned NUM_REGS         = 8
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       AXI_AWADDR,
    input  logic [2:0]                        AXI_AWPROT,
    input  logic                              AXI_AWVALID,
    output logic                              AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]       AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]     AXI_WSTRB,
    input  logic                              AXI_WVALID,
    output logic                              AXI_WREADY,
    output logic [1:0]                        AXI_BRESP,
    output logic                              AXI_BVALID,
    input  logic                              AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]       AXI_ARADDR,
    input  logic [2:0]                        AXI_ARPROT,
    input  logic                              AXI_ARVALID,
    output logic                              AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]       AXI_RDATA,
    output logic [1:0]                        AXI_RRESP,
    output logic                              AXI_RVALID,
    input  logic                              AXI_RREADY,
    output logic [(NUM_REGS/2)*32-1:0]        ctrl_out,
    input  logic [(NUM_REGS/2)*32-1:0]        status_in,
    output logic [NUM_REGS/2-1:0]             wr_pulse
);

    localparam int unsigned NCTRL = NUM_REGS / 2;
    localparam int unsigned IDX_W = C_AXI_ADDR_WIDTH - 2;
    localparam int unsigned SEL_W = (NCTRL > 1) ? $clog2(NCTRL) : 1;

    wr_state_t         wr_state, wr_state_next_c;
    rd_state_t         rd_state, rd_state_next_c;

    logic [IDX_W-1:0]  aw_idx;
    logic [31:0]       wdata_hold;
    logic [3:0]        wstrb_hold;

    logic              aw_hs_c, w_hs_c, b_hs_c, ar_hs_c, r_hs_c;
    logic              wr_commit_c;
    logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
    logic [SEL_W-1:0]  wr_sel_c, rd_sel_c;
    logic [31:0]       wr_data_c, rd_word_c;
    logic [3:0]        wr_strb_c;
    logic              wr_ctrl_c, rd_ctrl_c, rd_stat_c;
    resp_t             wr_resp_c, rd_resp_c;

    logic              unused_inputs_c;
    assign unused_inputs_c = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

    assign aw_hs_c = AXI_AWVALID && AXI_AWREADY;
    assign w_hs_c  = AXI_WVALID  && AXI_WREADY;
    assign b_hs_c  = AXI_BVALID  && AXI_BREADY;
    assign ar_hs_c = AXI_ARVALID && AXI_ARREADY;
    assign r_hs_c  = AXI_RVALID  && AXI_RREADY;

    // The final handshake may arrive directly from the bus rather than from the hold registers.
    assign wr_idx_c  = aw_hs_c ? AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2] : aw_idx;
    assign wr_data_c = w_hs_c  ? 32'(AXI_WDATA) : wdata_hold;
    assign wr_strb_c = w_hs_c  ? 4'(AXI_WSTRB)  : wstrb_hold;
    assign rd_idx_c  = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];

    // NCTRL is a power of two, so the low index bits select the word inside either bank.
    assign wr_sel_c  = wr_idx_c[SEL_W-1:0];
    assign rd_sel_c  = rd_idx_c[SEL_W-1:0];
    assign wr_ctrl_c = 32'(wr_idx_c) < NCTRL;
    assign rd_ctrl_c = 32'(rd_idx_c) < NCTRL;
    assign rd_stat_c = !rd_ctrl_c && (32'(rd_idx_c) < NUM_REGS);

`ifdef AXILITE_REG_SLAVE_SLVERR_EN
    assign wr_resp_c = wr_ctrl_c ? OKAY : SLVERR;
    assign rd_resp_c = (rd_ctrl_c || rd_stat_c) ? OKAY : SLVERR;
`else
    assign wr_resp_c = OKAY;
    assign rd_resp_c = OKAY;
`endif

    // Read mux; out-of-range words read as zero.
    always_comb begin
        rd_word_c = '0;
        for (int unsigned k = 0; k < NCTRL; k++) begin
            if (rd_sel_c == SEL_W'(k)) begin
                if (rd_ctrl_c) begin
                    rd_word_c = ctrl_out[32*k +: 32];
                end else if (rd_stat_c) begin
                    rd_word_c = status_in[32*k +: 32];
                end
            end
        end
    end

    // Write channel next state: AW and W may arrive in either order.
    always_comb begin
        wr_state_next_c = wr_state;
        unique case (wr_state)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    wr_state_next_c = W_RESP;
                end else if (aw_hs_c) begin
                    wr_state_next_c = W_HAVE_AW;
                end else if (w_hs_c) begin
                    wr_state_next_c = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs_c)  wr_state_next_c = W_RESP;
            W_HAVE_W:  if (aw_hs_c) wr_state_next_c = W_RESP;
            W_RESP:    if (b_hs_c)  wr_state_next_c = W_IDLE;
            default:   wr_state_next_c = W_IDLE;
        endcase
    end

    assign wr_commit_c = (wr_state != W_RESP) && (wr_state_next_c == W_RESP);

    // Read channel next state.
    always_comb begin
        rd_state_next_c = rd_state;
        unique case (rd_state)
            R_IDLE:  if (ar_hs_c) rd_state_next_c = R_RESP;
            R_RESP:  if (r_hs_c)  rd_state_next_c = R_IDLE;
            default: rd_state_next_c = R_IDLE;
        endcase
    end

    // Write channel state, registered handshake outputs and control registers.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            wr_state    <= W_IDLE;
            AXI_AWREADY <= 1'b0;
            AXI_WREADY  <= 1'b0;
            AXI_BVALID  <= 1'b0;
            AXI_BRESP   <= 2'b00;
            aw_idx      <= '0;
            wdata_hold  <= '0;
            wstrb_hold  <= '0;
            wr_pulse    <= '0;
            ctrl_out    <= '0;
        end else begin
            wr_state    <= wr_state_next_c;
            AXI_AWREADY <= (wr_state_next_c == W_IDLE) || (wr_state_next_c == W_HAVE_W);
            AXI_WREADY  <= (wr_state_next_c == W_IDLE) || (wr_state_next_c == W_HAVE_AW);
            AXI_BVALID  <= (wr_state_next_c == W_RESP);
            if (aw_hs_c) aw_idx <= wr_idx_c;
            if (w_hs_c) begin
                wdata_hold <= wr_data_c;
                wstrb_hold <= wr_strb_c;
            end
            if (wr_commit_c) AXI_BRESP <= wr_resp_c;
            for (int unsigned k = 0; k < NCTRL; k++) begin
                wr_pulse[k] <= wr_commit_c && wr_ctrl_c && (wr_sel_c == SEL_W'(k));
                if (wr_commit_c && wr_ctrl_c && (wr_sel_c == SEL_W'(k))) begin
                    ctrl_out[32*k +: 32] <= strb_merge(ctrl_out[32*k +: 32], wr_data_c, wr_strb_c);
                end
            end
        end
    end

    // Read channel state; data is captured at the AR handshake and held until the R handshake.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            rd_state    <= R_IDLE;
            AXI_ARREADY <= 1'b0;
            AXI_RVALID  <= 1'b0;
            AXI_RDATA   <= '0;
            AXI_RRESP   <= 2'b00;
        end else begin
            rd_state    <= rd_state_next_c;
            AXI_ARREADY <= (rd_state_next_c == R_IDLE);
            AXI_RVALID  <= (rd_state_next_c == R_RESP);
            if (ar_hs_c) begin
                AXI_RDATA <= C_AXI_DATA_WIDTH'(rd_word_c);
                AXI_RRESP <= rd_resp_c;
            end
        end
    end

endmodule
